// File: rtl/hilo_div.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write port, one quotient bit per cycle.
module hilo_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);
    localparam int unsigned RegWidth = 32;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [4:0]              r_cnt;
    logic [RegWidth-1:0]     r_quo;
    logic [RegWidth-1:0]     r_rem;
    logic [RegWidth-1:0]     r_dvs;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [2*RegWidth-1:0]   r_result;

    logic [RegWidth:0]       w_diff;
    logic                    w_qbit;
    logic [RegWidth-1:0]     w_rem_next;
    logic [RegWidth-1:0]     w_quo_next;
    logic [RegWidth-1:0]     w_quo_fix;
    logic [RegWidth-1:0]     w_rem_fix;
    logic [RegWidth-1:0]     w_abs1;
    logic [RegWidth-1:0]     w_abs2;

    // r_quo starts as |dividend| and its MSBs are consumed as quotient bits shift in.
    always_comb begin
        w_diff     = {r_rem, r_quo[RegWidth-1]} - {1'b0, r_dvs};
        w_qbit     = ~w_diff[RegWidth];
        w_rem_next = w_qbit ? w_diff[RegWidth-1:0] : {r_rem[RegWidth-2:0], r_quo[RegWidth-1]};
        w_quo_next = {r_quo[RegWidth-2:0], w_qbit};
        w_quo_fix  = r_neg_q ? (~w_quo_next + 32'd1) : w_quo_next;
        w_rem_fix  = r_neg_r ? (~w_rem_next + 32'd1) : w_rem_next;
        w_abs1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        w_abs2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FREE: begin
                if (start_i && !annul_i) begin
                    w_next = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: w_next = annul_i ? FREE : END;
            ON: begin
                if (annul_i) begin
                    w_next = FREE;
                end else if (r_cnt == 5'd31) begin
                    w_next = END;
                end
            end
            END: begin
                if (!start_i) begin
                    w_next = FREE;
                end
            end
            default: w_next = FREE;
        endcase
        busy_o   = (r_state == ON) || (r_state == BYZERO);
        ready_o  = (r_state == END);
        result_o = (r_state == END) ? r_result : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    r_result <= '0;
                    if (start_i && !annul_i) begin
                        r_quo   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r <= signed_div_i & opdata1_i[31];
                    end
                end
                BYZERO: r_result <= '0;
                ON: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div.sv
// Self-checking bench for hilo_div: cycle-level timing model plus arithmetic reference,
// directed vectors from the test plan and randomized operations with annuls.
module tb_hilo_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hilo_div dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .annul_i     (annul),
        .signed_div_i(sgn),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .result_o    (result),
        .ready_o     (ready),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic: 64-bit signed math cannot overflow for 32-bit operands.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] la, lb, q, r;
        if (b == 32'd0) return '0;
        la = s ? {{32{a[31]}}, a} : {32'd0, a};
        lb = s ? {{32{b[31]}}, b} : {32'd0, b};
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Timing model: remaining busy cycles, then a done phase held while start stays high.
    int          m_left;
    logic        m_done;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_done) begin
            if (!start) m_done <= 1'b0;
        end else if (m_left != 0) begin
            if (annul) m_left <= 0;
            else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
            end else m_left <= m_left - 1;
        end else if (start && !annul) begin
            m_left <= (op2 == 32'd0) ? 1 : 32;
            m_res  <= ref_div(sgn, op1, op2);
        end
    end

    always @(negedge clk) begin
        check("cycle_outputs", {busy, ready, result},
              {(m_left != 0), m_done, (m_done ? m_res : 64'd0)});
    end

    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        sgn = s; op1 = a; op2 = b; start = 1'b1;
        n = 0;
        while (n < 40 && !ready) begin
            @(posedge clk); #1;
            n++;
            op1 = $urandom; op2 = $urandom; sgn = 1'($urandom);
        end
        check({name, "_latency"}, 66'(n), 66'(lat));
        check({name, "_result"}, {2'b01, result}, {2'b01, exp});
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check({name, "_hold"}, {busy, ready, result}, {2'b01, exp});
        start = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop"}, {busy, ready, result}, 66'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        logic s, abort;
        logic [31:0] a, b;
        int   k, abort_at, hold;

        #1;
        check("reset_outputs", {busy, ready, result}, 66'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("model_100_7",   {2'b00, ref_div(1'b0, 32'd100, 32'd7)}, {2'b00, 32'd2, 32'd14});
        check("model_m7_2",    {2'b00, ref_div(1'b1, 32'hFFFFFFF9, 32'd2)}, {2'b00, 64'hFFFFFFFF_FFFFFFFD});
        check("model_7_m2",    {2'b00, ref_div(1'b1, 32'd7, 32'hFFFFFFFE)}, {2'b00, 64'h00000001_FFFFFFFD});
        check("model_ovf",     {2'b00, ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF)}, {2'b00, 64'h00000000_80000000});
        check("model_byzero",  {2'b00, ref_div(1'b0, 32'd5, 32'd0)}, 66'd0);

        run_div("u100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
        run_div("s_m7_2",  1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s_7_m2",  1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33);
        run_div("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
        run_div("u_div0",  1'b0, 32'd1234,       32'd0,          64'd0, 2);
        run_div("s_div0",  1'b1, 32'h80000001,   32'd0,          64'd0, 2);

        // start with annul held in FREE is ignored
        sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("annul_in_free", {busy, ready, result}, 66'd0);
        start = 1'b0; annul = 1'b0;
        @(posedge clk); #1;

        // annul in cycle 10 of a division
        sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_to_free", {busy, ready, result}, 66'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check("annul_no_ready", 66'(seen), 66'd0);
        run_div("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // asynchronous reset mid-ON
        sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        check("async_reset", {busy, ready, result}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_div("after_reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // randomized operations, some annulled at a random busy cycle
        for (int it = 0; it < 30; it++) begin
            s = 1'($urandom);
            a = $urandom;
            k = $urandom_range(0, 4);
            case (k)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: b = $urandom;
            endcase
            abort    = ($urandom_range(0, 4) == 0);
            abort_at = $urandom_range(1, (b == 32'd0) ? 1 : 32);
            sgn = s; op1 = a; op2 = b; start = 1'b1;
            n = 0;
            while (n < 40 && !ready && start) begin
                @(posedge clk); #1;
                n++;
                op1 = $urandom; op2 = $urandom;
                if (abort && n == abort_at) begin
                    annul = 1'b1; start = 1'b0;
                    @(posedge clk); #1;
                    annul = 1'b0;
                end
            end
            if (!abort) check("rand_ready", 66'(ready), 66'd1);
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
